// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg
//   Shared constants and helpers for the multiplexed 7-segment display
//   controller: cathode patterns, converter FSM state encodings, the
//   BCD-digit-to-segment decoder and a constant power-of-ten function used
//   to size the overflow threshold.
//   Segment patterns are active-low, ordered {a,b,c,d,e,f,g}.
package seven_seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  // Converter FSM encodings
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
    logic [6:0] seg;
    case (d)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // 10**n evaluated at elaboration time; n is limited so the result fits 32 bits.
  function automatic logic [31:0] pow10(input int n);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 32'd10;
    end
    return p;
  endfunction

endpackage

// File: rtl/seven_seg_display_ctrl_bin2bcd_seq.sv
// bin2bcd_seq
//   Iterative double-dabble binary-to-BCD converter with a valid/ready
//   input handshake. One input bit is consumed per cycle, so a conversion
//   takes DATA_W SHIFT cycles plus one COMMIT cycle. Committed digits and
//   the overflow flag only change in COMMIT, so consumers never observe a
//   half-converted value.
//
// Ports
//   clock_100Mhz  in   system clock
//   reset         in   synchronous, active-high
//   value_in      in   [DATA_W]       unsigned binary value
//   value_valid   in   value_in offered
//   value_ready   out  high only while idle
//   bcd_digits    out  [NUM_DIGITS*4] committed BCD, digit 0 in bits [3:0]
//   overflow      out  committed value needed more than NUM_DIGITS digits
module bin2bcd_seq
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_W     = 16
) (
  input  logic                    clock_100Mhz,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       value_in,
  input  logic                    value_valid,
  output logic                    value_ready,
  output logic [NUM_DIGITS*4-1:0] bcd_digits,
  output logic                    overflow
);

  localparam int          BCD_W     = NUM_DIGITS * 4;
  localparam int          CNT_W     = $clog2(DATA_W + 1);
  localparam logic [31:0] OVF_LIMIT = pow10(NUM_DIGITS);

  logic [1:0]        state;
  logic [CNT_W-1:0]  shift_cnt;
  logic [DATA_W-1:0] bin_sr;
  logic [BCD_W-1:0]  bcd_acc;
  logic [BCD_W-1:0]  bcd_adj;
  logic              ovf_pending;
  logic              transfer;

  assign value_ready = (state == ST_IDLE);
  assign transfer    = value_valid && value_ready;

  // Double-dabble correction: any nibble >= 5 would exceed 9 after the
  // doubling shift, so pre-add 3 to carry into the next decade instead.
  always_comb begin
    bcd_adj = bcd_acc;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_acc[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd_acc[i*4 +: 4] + 4'd3;
      end
    end
  end

  // Control: FSM, shift counter, committed result
  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      state      <= ST_IDLE;
      shift_cnt  <= '0;
      bcd_digits <= '0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (transfer) begin
            state     <= ST_SHIFT;
            shift_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          shift_cnt <= shift_cnt + CNT_W'(1);
          if (shift_cnt == CNT_W'(DATA_W - 1)) begin
            state <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          bcd_digits <= bcd_acc;
          overflow   <= ovf_pending;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Datapath: shift register and BCD accumulator. Bits leaving the top of
  // the accumulator are dropped; out-of-range values are caught up front
  // by the threshold compare instead.
  always_ff @(posedge clock_100Mhz) begin
    if (transfer) begin
      bin_sr      <= value_in;
      bcd_acc     <= '0;
      ovf_pending <= (32'(value_in) >= OVF_LIMIT);
    end else if (state == ST_SHIFT) begin
      bcd_acc <= {bcd_adj[BCD_W-2:0], bin_sr[DATA_W-1]};
      bin_sr  <= bin_sr << 1;
    end
  end

endmodule

// File: rtl/seven_seg_display_ctrl.sv
// seven_seg_display_ctrl
//   Multiplexed 7-segment display controller. Accepts a binary value via
//   valid/ready, converts it to BCD (bin2bcd_seq) and scans NUM_DIGITS
//   digits onto shared cathodes, each digit active for REFRESH_DIV cycles.
//   Leading zeros can be blanked; an out-of-range value shows dashes.
//
// Ports
//   clock_100Mhz    in   system clock
//   reset           in   synchronous, active-high
//   value_in        in   [DATA_W] unsigned value to display
//   value_valid     in   value_in offered
//   value_ready     out  controller can accept a value
//   blank_lz        in   1 = blank leading zeros
//   overflow        out  displayed value exceeded NUM_DIGITS digits
//   Anode_Activate  out  [NUM_DIGITS] active-low digit enables
//   LED_out         out  [7] active-low cathodes {a,b,c,d,e,f,g}
module seven_seg_display_ctrl
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int DATA_W      = 16,
  parameter int REFRESH_DIV = 262144
) (
  input  logic                  clock_100Mhz,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     value_in,
  input  logic                  value_valid,
  output logic                  value_ready,
  input  logic                  blank_lz,
  output logic                  overflow,
  output logic [NUM_DIGITS-1:0] Anode_Activate,
  output logic [6:0]            LED_out
);

  localparam int SCAN_W = $clog2(REFRESH_DIV);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [NUM_DIGITS*4-1:0] bcd_digits;
  logic [SCAN_W-1:0]       scan_cnt;
  logic [IDX_W-1:0]        digit_idx;
  logic [3:0]              sel_digit;
  logic                    upper_nz;
  logic [6:0]              seg_next;
  logic [NUM_DIGITS-1:0]   anode_next;

  bin2bcd_seq #(
    .NUM_DIGITS (NUM_DIGITS),
    .DATA_W     (DATA_W)
  ) u_bin2bcd (
    .clock_100Mhz (clock_100Mhz),
    .reset        (reset),
    .value_in     (value_in),
    .value_valid  (value_valid),
    .value_ready  (value_ready),
    .bcd_digits   (bcd_digits),
    .overflow     (overflow)
  );

  // Scan timing: dwell counter, digit index advances on each wrap
  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (scan_cnt == SCAN_W'(REFRESH_DIV - 1)) begin
      scan_cnt  <= '0;
      digit_idx <= (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  // A digit is a leading zero when it and every more-significant digit are
  // zero; units is exempt so a zero value still shows "0".
  always_comb begin
    sel_digit  = 4'd0;
    upper_nz   = 1'b0;
    anode_next = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (IDX_W'(k) == digit_idx) begin
        sel_digit     = bcd_digits[k*4 +: 4];
        anode_next[k] = 1'b0;
      end
      if ((IDX_W'(k) >= digit_idx) && (bcd_digits[k*4 +: 4] != 4'd0)) begin
        upper_nz = 1'b1;
      end
    end
    if (overflow) begin
      seg_next = SEG_DASH;
    end else if (blank_lz && (digit_idx != '0) && !upper_nz) begin
      seg_next = SEG_BLANK;
    end else begin
      seg_next = digit_to_seg(sel_digit);
    end
  end

  // Output register: anode and cathodes update on the same edge so no
  // digit ever flashes another digit's pattern.
  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      Anode_Activate <= '1;
      LED_out        <= SEG_BLANK;
    end else begin
      Anode_Activate <= anode_next;
      LED_out        <= seg_next;
    end
  end

endmodule

// File: tb/tb_seven_seg_display_ctrl.sv
module tb_seven_seg_display_ctrl;

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] S7 = 7'b0001111;
  localparam logic [6:0] S9 = 7'b0000100;
  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [6:0] SD = 7'b1111110;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        blank_lz;
  logic [15:0] a_in;
  logic        a_valid, a_ready, a_ovf;
  logic [3:0]  a_anode;
  logic [6:0]  a_led;
  logic [19:0] b_in;
  logic        b_valid, b_ready, b_ovf;
  logic [5:0]  b_anode;
  logic [6:0]  b_led;

  seven_seg_display_ctrl #(.NUM_DIGITS(4), .DATA_W(16), .REFRESH_DIV(4)) dut_a (
    .clock_100Mhz   (clk),
    .reset          (reset),
    .value_in       (a_in),
    .value_valid    (a_valid),
    .value_ready    (a_ready),
    .blank_lz       (blank_lz),
    .overflow       (a_ovf),
    .Anode_Activate (a_anode),
    .LED_out        (a_led)
  );

  seven_seg_display_ctrl #(.NUM_DIGITS(6), .DATA_W(20), .REFRESH_DIV(4)) dut_b (
    .clock_100Mhz   (clk),
    .reset          (reset),
    .value_in       (b_in),
    .value_valid    (b_valid),
    .value_ready    (b_ready),
    .blank_lz       (blank_lz),
    .overflow       (b_ovf),
    .Anode_Activate (b_anode),
    .LED_out        (b_led)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [7:0] cur_anode(input bit sel);
    return sel ? {2'b11, b_anode} : {4'hF, a_anode};
  endfunction
  function automatic logic [6:0] cur_led(input bit sel);
    return sel ? b_led : a_led;
  endfunction
  function automatic logic cur_ready(input bit sel);
    return sel ? b_ready : a_ready;
  endfunction

  // Handshake one value; returns 1ns after the transfer edge.
  task automatic start(input bit sel, input logic [19:0] v);
    int n;
    n = 0;
    while (!cur_ready(sel) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_load", {63'd0, cur_ready(sel)}, 64'd1);
    if (sel) begin b_in = v; b_valid = 1'b1; end
    else begin a_in = v[15:0]; a_valid = 1'b1; end
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  // Counts negedge samples with value_ready low after the transfer.
  task automatic finish_wait(input bit sel, output int lat);
    lat = 0;
    @(negedge clk);
    while (!cur_ready(sel) && lat < 200) begin
      lat++;
      @(negedge clk);
    end
  endtask

  // Watches more than one full scan, records each digit's cathodes and
  // verifies one-cold anodes visited in ascending wrapping order.
  task automatic capture(input bit sel, input int nd, output logic [55:0] segs, output bit seq_ok);
    logic [6:0] s [8];
    logic [7:0] seen;
    int prev, k;
    seen = '0;
    prev = -1;
    seq_ok = 1'b1;
    for (int j = 0; j < 8; j++) s[j] = 7'h00;
    repeat (nd * 4 + 4) begin
      @(negedge clk);
      k = -1;
      for (int j = 0; j < nd; j++) if (cur_anode(sel) == ~(8'd1 << j)) k = j;
      if (k < 0) seq_ok = 1'b0;
      else begin
        s[k] = cur_led(sel);
        seen[k] = 1'b1;
        if (prev >= 0 && k != prev && k != (prev + 1) % nd) seq_ok = 1'b0;
        prev = k;
      end
    end
    for (int j = 0; j < nd; j++) if (!seen[j]) seq_ok = 1'b0;
    segs = '0;
    for (int j = 0; j < 8; j++) segs[j*7 +: 7] = s[j];
  endtask

  typedef struct {
    logic [15:0] val;
    logic        bl;
    logic        ovf;
    logic [27:0] segs;  // {digit3, digit2, digit1, digit0}
  } vec_t;

  vec_t tbl [10];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [55:0] segs;
    bit seq_ok;
    int lat;

    tbl[0] = '{16'd1234,  1'b0, 1'b0, {S1, S2, S3, S4}};
    tbl[1] = '{16'd42,    1'b1, 1'b0, {SB, SB, S4, S2}};
    tbl[2] = '{16'd0,     1'b1, 1'b0, {SB, SB, SB, S0}};
    tbl[3] = '{16'd1004,  1'b1, 1'b0, {S1, S0, S0, S4}};
    tbl[4] = '{16'd42,    1'b0, 1'b0, {S0, S0, S4, S2}};
    tbl[5] = '{16'd10000, 1'b0, 1'b1, {SD, SD, SD, SD}};
    tbl[6] = '{16'hFFFF,  1'b1, 1'b1, {SD, SD, SD, SD}};
    tbl[7] = '{16'd9999,  1'b0, 1'b0, {S9, S9, S9, S9}};
    tbl[8] = '{16'd9,     1'b1, 1'b0, {SB, SB, SB, S9}};
    tbl[9] = '{16'd100,   1'b1, 1'b0, {SB, S1, S0, S0}};

    reset = 1'b1; blank_lz = 1'b0;
    a_in = '0; a_valid = 1'b0; b_in = '0; b_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_anode_a", {60'd0, a_anode}, 64'hF);
    chk("rst_led_a", {57'd0, a_led}, 64'h7F);
    chk("rst_ready_a", {63'd0, a_ready}, 64'd1);
    chk("rst_ovf_a", {63'd0, a_ovf}, 64'd0);
    chk("rst_anode_b", {58'd0, b_anode}, 64'h3F);
    chk("rst_ovf_b", {63'd0, b_ovf}, 64'd0);
    reset = 1'b0;

    capture(1'b0, 4, segs, seq_ok);
    chk("post_rst_segs", {36'd0, segs[27:0]}, {36'd0, S0, S0, S0, S0});
    chk("post_rst_seq", {63'd0, seq_ok}, 64'd1);

    for (int i = 0; i < 10; i++) begin
      blank_lz = tbl[i].bl;
      start(1'b0, {4'd0, tbl[i].val});
      finish_wait(1'b0, lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd17);
      chk($sformatf("vec%0d_ovf", i), {63'd0, a_ovf}, {63'd0, tbl[i].ovf});
      capture(1'b0, 4, segs, seq_ok);
      chk($sformatf("vec%0d_segs", i), {36'd0, segs[27:0]}, {36'd0, tbl[i].segs});
      chk($sformatf("vec%0d_scan_order", i), {63'd0, seq_ok}, 64'd1);
    end

    // blank_lz takes effect without reloading (display holds 100)
    blank_lz = 1'b0;
    capture(1'b0, 4, segs, seq_ok);
    chk("live_blank_off", {36'd0, segs[27:0]}, {36'd0, S0, S1, S0, S0});

    // Reset held 3 cycles mid-scan while overflow is showing
    start(1'b0, 20'hFFFF);
    finish_wait(1'b0, lat);
    chk("pre_rst_ovf", {63'd0, a_ovf}, 64'd1);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midscan_rst_anode", {60'd0, a_anode}, 64'hF);
    chk("midscan_rst_led", {57'd0, a_led}, 64'h7F);
    chk("midscan_rst_ready", {63'd0, a_ready}, 64'd1);
    chk("midscan_rst_ovf", {63'd0, a_ovf}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    capture(1'b0, 4, segs, seq_ok);
    chk("after_midscan_rst_segs", {36'd0, segs[27:0]}, {36'd0, S0, S0, S0, S0});

    // value_valid while busy is dropped, not queued
    start(1'b0, 20'd1234);
    repeat (4) @(negedge clk);
    chk("busy_when_pulsed", {63'd0, a_ready}, 64'd0);
    a_in = 16'd5555; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    finish_wait(1'b0, lat);
    repeat (3) @(negedge clk);
    chk("no_queued_load", {63'd0, a_ready}, 64'd1);
    capture(1'b0, 4, segs, seq_ok);
    chk("ignored_valid_segs", {36'd0, segs[27:0]}, {36'd0, S1, S2, S3, S4});

    // Reset during SHIFT aborts the conversion
    start(1'b0, 20'd9999);
    repeat (5) @(negedge clk);
    chk("shift_busy", {63'd0, a_ready}, 64'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("shift_rst_ready", {63'd0, a_ready}, 64'd1);
    repeat (25) @(negedge clk);
    chk("shift_rst_ovf", {63'd0, a_ovf}, 64'd0);
    capture(1'b0, 4, segs, seq_ok);
    chk("shift_rst_segs", {36'd0, segs[27:0]}, {36'd0, S0, S0, S0, S0});
    blank_lz = 1'b1;
    start(1'b0, 20'd77);
    finish_wait(1'b0, lat);
    chk("after_abort_latency", 64'(lat), 64'd17);
    capture(1'b0, 4, segs, seq_ok);
    chk("after_abort_segs", {36'd0, segs[27:0]}, {36'd0, SB, SB, S7, S7});

    // Six-digit, 20-bit instance
    blank_lz = 1'b0;
    start(1'b1, 20'd999999);
    finish_wait(1'b1, lat);
    chk("b_latency", 64'(lat), 64'd21);
    chk("b_999999_ovf", {63'd0, b_ovf}, 64'd0);
    capture(1'b1, 6, segs, seq_ok);
    chk("b_999999_segs", {22'd0, segs[41:0]}, {22'd0, {6{S9}}});
    chk("b_scan_order", {63'd0, seq_ok}, 64'd1);
    start(1'b1, 20'd1000000);
    finish_wait(1'b1, lat);
    chk("b_1000000_ovf", {63'd0, b_ovf}, 64'd1);
    capture(1'b1, 6, segs, seq_ok);
    chk("b_1000000_segs", {22'd0, segs[41:0]}, {22'd0, {6{SD}}});

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
